// File: rtl/viterbi_hard_decoder.sv
// viterbi_hard_decoder: hard-decision Viterbi decoder for a rate-1/2 convolutional code,
// with a circular survivor buffer, per-bit traceback and terminated-block flush.
module viterbi_hard_decoder #(
    parameter int K        = 3,
    parameter int G0       = 'o7,
    parameter int G1       = 'o5,
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_bits,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit
);
    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int RW = $clog2(TB_DEPTH);
    localparam int FW = $clog2(TB_DEPTH + 1);
    localparam logic [K-1:0]    GA       = K'(G0);
    localparam logic [K-1:0]    GB       = K'(G1);
    localparam logic [PM_W-1:0] PM_INIT  = PM_W'(1) << (PM_W - 2);
    localparam logic [PM_W:0]   HALF     = (PM_W + 1)'(1) << (PM_W - 1);
    localparam logic [PM_W:0]   PM_MAX   = {1'b0, {PM_W{1'b1}}};
    localparam logic [RW-1:0]   LAST_ROW = RW'(TB_DEPTH - 1);
    localparam logic [FW-1:0]   DEPTH    = FW'(TB_DEPTH);

    typedef enum logic [1:0] {ACCEPT, TRACE, EMIT} state_t;

    state_t            state, state_nx;
    logic [PM_W-1:0]   pm     [NS];
    logic [PM_W-1:0]   pm_nx  [NS];
    logic [PM_W:0]     acs    [NS];
    logic [NS-1:0]     surv   [TB_DEPTH];
    logic [NS-1:0]     dec;
    logic [RW-1:0]     wr_ptr, tb_row, newest, row, row_prev;
    logic [FW-1:0]     fill, tb_cnt;
    logic              flushing, accept, emit_hs, last_step;
    logic [SW-1:0]     tb_state, best, cur, prev, sv, p0, p1;
    logic [PM_W-1:0]   best_pm;
    logic [PM_W:0]     m0, m1, acs_min, nrm;

    function automatic logic [1:0] bm(input logic [K-1:0] r, input logic [1:0] sym);
        return {1'b0, ^(r & GA) ^ sym[1]} + {1'b0, ^(r & GB) ^ sym[0]};
    endfunction

    // Add-compare-select; ties favour the b=0 predecessor, sums are one bit wider than PM
    always_comb begin
        acs_min = '1;
        dec     = '0;
        sv      = '0;
        p0      = '0;
        p1      = '0;
        m0      = '0;
        m1      = '0;
        nrm     = '0;
        for (int s = 0; s < NS; s++) begin
            sv     = SW'(s);
            p0     = {sv[SW-2:0], 1'b0};
            p1     = {sv[SW-2:0], 1'b1};
            m0     = {1'b0, pm[p0]} + {{(PM_W - 1){1'b0}}, bm({sv[SW-1], p0}, in_bits)};
            m1     = {1'b0, pm[p1]} + {{(PM_W - 1){1'b0}}, bm({sv[SW-1], p1}, in_bits)};
            dec[s] = m1 < m0;
            acs[s] = dec[s] ? m1 : m0;
            if (acs[s] < acs_min) acs_min = acs[s];
        end
        for (int s = 0; s < NS; s++) begin
            nrm      = (acs_min >= HALF) ? acs[s] - HALF : acs[s];
            pm_nx[s] = (nrm > PM_MAX) ? '1 : nrm[PM_W-1:0];
        end
    end

    always_comb begin
        best    = '0;
        best_pm = pm[0];
        for (int s = 1; s < NS; s++)
            if (pm[s] < best_pm) begin
                best_pm = pm[s];
                best    = SW'(s);
            end
    end

    // Traceback step: first TRACE cycle starts at the newest row, later cycles walk backwards
    always_comb begin
        newest    = (wr_ptr == '0) ? LAST_ROW : wr_ptr - 1'b1;
        cur       = (tb_cnt == '0) ? (flushing ? '0 : best) : tb_state;
        row       = (tb_cnt == '0) ? newest : tb_row;
        prev      = {cur[SW-2:0], surv[row][cur]};
        row_prev  = (row == '0) ? LAST_ROW : row - 1'b1;
        last_step = tb_cnt == fill - 1'b1;
        accept    = (state == ACCEPT) && in_valid;
        emit_hs   = (state == EMIT) && out_ready;
        in_ready  = state == ACCEPT;
        out_valid = state == EMIT;
    end

    always_comb begin
        state_nx = state;
        if (accept && (fill + 1'b1 == DEPTH || in_last)) state_nx = TRACE;
        if (state == TRACE && last_step) state_nx = EMIT;
        if (emit_hs) state_nx = (flushing && fill > FW'(1)) ? TRACE : ACCEPT;
    end

    always_ff @(posedge clk)
        if (accept) surv[wr_ptr] <= dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCEPT;
            fill     <= '0;
            wr_ptr   <= '0;
            flushing <= 1'b0;
            tb_cnt   <= '0;
            tb_row   <= '0;
            tb_state <= '0;
            out_bit  <= 1'b0;
            for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : PM_INIT;
        end else begin
            state <= state_nx;
            if (accept) begin
                for (int s = 0; s < NS; s++) pm[s] <= pm_nx[s];
                wr_ptr   <= (wr_ptr == LAST_ROW) ? '0 : wr_ptr + 1'b1;
                fill     <= fill + 1'b1;
                flushing <= in_last;
            end
            if (state == TRACE) begin
                tb_state <= prev;
                tb_row   <= row_prev;
                tb_cnt   <= last_step ? '0 : tb_cnt + 1'b1;
                if (last_step) out_bit <= cur[SW-1];
            end
            if (emit_hs) begin
                fill <= fill - 1'b1;
                if (flushing && fill == FW'(1)) begin
                    flushing <= 1'b0;
                    for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : PM_INIT;
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_hard_decoder.sv
// tb_viterbi_hard_decoder: directed vectors for K=3/TB_DEPTH=4 plus an error-free K=5 stream
// checked against a bench-side encoder.
module tb_viterbi_hard_decoder;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_bit;
    logic [1:0] a_in_bits;
    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_bit;
    logic [1:0] b_in_bits;

    viterbi_hard_decoder #(.K(3), .G0('o7), .G1('o5), .TB_DEPTH(4), .PM_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_bits(a_in_bits), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_bit(a_out_bit));

    viterbi_hard_decoder #(.K(5), .G0('o23), .G1('o35), .TB_DEPTH(20), .PM_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bits(b_in_bits), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_bit(b_out_bit));

    typedef struct {
        logic [1:0] bits;
        logic       last;
        logic       exp;
    } vec_t;

    vec_t tbl[13];
    int   passed = 0, total = 0, rx_cyc = 0;
    logic info[204];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic send_a(input logic [1:0] bits, input logic last);
        int t = 0;
        a_in_valid = 1'b1; a_in_bits = bits; a_in_last = last;
        while (!a_in_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!a_in_ready) check("send_a_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic recv_a(output logic b);
        int t = 0;
        while (!a_out_valid && t < 300) begin @(posedge clk); #1; t++; end
        b = a_out_valid ? a_out_bit : 1'bx;
        rx_cyc = cyc;
        if (a_out_valid) begin @(posedge clk); #1; end
    endtask

    task automatic send_b(input logic [1:0] bits, input logic last);
        int t = 0;
        b_in_valid = 1'b1; b_in_bits = bits; b_in_last = last;
        while (!b_in_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!b_in_ready) check("send_b_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic recv_b(output logic b);
        int t = 0;
        while (!b_out_valid && t < 300) begin @(posedge clk); #1; t++; end
        b = b_out_valid ? b_out_bit : 1'bx;
        if (b_out_valid) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic r;
        a_in_valid = 0; a_in_bits = 0; a_in_last = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_bits = 0; b_in_last = 0; b_out_ready = 1;
        // short terminated block, fill < TB_DEPTH at in_last
        tbl[0]  = '{2'b11, 1'b0, 1'b1};
        tbl[1]  = '{2'b10, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b0};
        // in_last coincides with a full buffer
        tbl[3]  = '{2'b00, 1'b0, 1'b0};
        tbl[4]  = '{2'b11, 1'b0, 1'b1};
        tbl[5]  = '{2'b10, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0};
        // third symbol corrupted 00 -> 10
        tbl[7]  = '{2'b11, 1'b0, 1'b1};
        tbl[8]  = '{2'b10, 1'b0, 1'b0};
        tbl[9]  = '{2'b10, 1'b0, 1'b1};
        tbl[10] = '{2'b01, 1'b0, 1'b1};
        tbl[11] = '{2'b01, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_bit", a_out_bit, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", a_in_ready, 1);

        fork
            for (int i = 0; i < 13; i++) send_a(tbl[i].bits, tbl[i].last);
            for (int i = 0; i < 13; i++) begin
                logic b;
                recv_a(b);
                check($sformatf("tbl_bit%0d", i), b, tbl[i].exp);
            end
        join
        check("flush_in_ready", a_in_ready, 1);
        check("flush_pm0", dut_a.pm[0], 0);
        check("flush_pm3", dut_a.pm[3], 4);

        // back-pressure: hold the first decoded bit for 10 cycles
        a_out_ready = 1'b0;
        send_a(2'b00, 0); send_a(2'b11, 0); send_a(2'b10, 0); send_a(2'b11, 1);
        for (int t = 0; t < 300 && !a_out_valid; t++) begin @(posedge clk); #1; end
        check("bp_valid", a_out_valid, 1);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", a_out_valid, 1);
            check("bp_hold_bit", a_out_bit, 0);
            check("bp_in_ready", a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        recv_a(r); check("bp_bit0", r, 0);
        recv_a(r); check("bp_bit1", r, 1);
        recv_a(r); check("bp_bit2", r, 0);
        recv_a(r); check("bp_bit3", r, 0);

        // long 11 stream with narrow metrics: throughput must stay one bit per TB_DEPTH+2
        fork
            repeat (40) send_a(2'b11, 0);
            begin
                int prev = 0;
                for (int k = 0; k < 37; k++) begin
                    logic b;
                    recv_a(b);
                    check("norm_known", $isunknown(b), 0);
                    if (k > 0) check("norm_period", rx_cyc - prev, 6);
                    prev = rx_cyc;
                end
            end
        join

        // abort mid-traceback
        send_a(2'b11, 0);
        @(posedge clk); #1;
        check("trace_busy", a_in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", a_out_valid, 0);
        check("abort_in_ready", a_in_ready, 1);
        check("abort_fill", dut_a.fill, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork
            begin
                send_a(2'b11, 0); send_a(2'b10, 0); send_a(2'b00, 0);
                send_a(2'b01, 0); send_a(2'b01, 0); send_a(2'b11, 1);
            end
            begin
                recv_a(r); check("post_rst0", r, 1);
                recv_a(r); check("post_rst1", r, 0);
                recv_a(r); check("post_rst2", r, 1);
                recv_a(r); check("post_rst3", r, 1);
                recv_a(r); check("post_rst4", r, 0);
                recv_a(r); check("post_rst5", r, 0);
            end
        join

        // K=5 stream, zero tail terminates the trellis
        for (int i = 0; i < 204; i++) info[i] = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
        fork
            begin
                logic [3:0] st = '0;
                logic [4:0] rg;
                for (int i = 0; i < 204; i++) begin
                    rg = {info[i], st};
                    st = {info[i], st[3:1]};
                    send_b({^(rg & 5'o23), ^(rg & 5'o35)}, i == 203);
                end
            end
            for (int i = 0; i < 204; i++) begin
                logic b;
                recv_b(b);
                check($sformatf("k5_bit%0d", i), b, info[i]);
            end
        join

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
